// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single-precision subtractor (resultSub = A - B).
// Sequence: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE, with valid/ready on both sides.
// Optional build macro FPU_SUB_SPECIAL_EN enables zero/Inf/NaN decode; without it every
// operand carries an implicit leading one and the exponent field is used as-is.
module fp_sub_seq #(
  parameter int ALIGN_SAT = 26,
  parameter int NORM_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  round_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] resultSub,
  output logic        overflowSub,
  output logic        underflowSub,
  output logic        errorSub
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADDSUB,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      state;

  // Operand X always holds the larger magnitude; Y is the one being aligned.
  // Mantissas are 27 bits: {hidden, fraction[22:0], guard, round, sticky}.
  logic        sign_x;
  logic        sign_y;
  logic [9:0]  exp_x;
  logic [26:0] man_x;
  logic [26:0] man_y;
  logic [7:0]  cnt;
  logic [1:0]  rm;
  logic        special_q;
  logic [31:0] spec_res_q;
  logic        spec_err_q;

  // Accept-time decode: magnitude order, effective signs, mantissas, shift count
  logic        swap;
  logic [30:0] big_mag;
  logic [30:0] small_mag;
  logic        big_sign;
  logic        small_sign;
  logic        hid_big;
  logic        hid_small;
  logic [7:0]  exp_diff;
  logic [7:0]  shift_init;
  logic        spec_hit;
  logic [31:0] spec_res;
  logic        spec_err;

  // Datapath helpers for ADDSUB, NORM and ROUND
  logic [27:0] sum;
  logic [9:0]  norm_amt;
  logic        round_inc;
  logic [24:0] rounded;
  logic [9:0]  exp_r;
  logic [23:0] mant_r;

  // Decode the incoming operands so the accept edge can load X/Y already ordered
  always_comb begin
    swap       = B[30:0] > A[30:0];
    big_mag    = swap ? B[30:0] : A[30:0];
    small_mag  = swap ? A[30:0] : B[30:0];
    big_sign   = swap ? ~B[31] : A[31];
    small_sign = swap ? A[31] : ~B[31];
    exp_diff   = big_mag[30:23] - small_mag[30:23];
    shift_init = (exp_diff > 8'(ALIGN_SAT)) ? 8'(ALIGN_SAT) : exp_diff;
`ifdef FPU_SUB_SPECIAL_EN
    hid_big    = |big_mag[30:23];
    hid_small  = |small_mag[30:23];
    spec_hit   = (&A[30:23]) | (&B[30:23]);
    spec_res   = 32'h0;
    spec_err   = 1'b0;
    if (((&A[30:23]) && (|A[22:0])) || ((&B[30:23]) && (|B[22:0])) ||
        ((&A[30:23]) && (&B[30:23]) && (A[31] == B[31]))) begin
      spec_res = 32'h7FC00000;
      spec_err = 1'b1;
    end else if (&A[30:23]) begin
      spec_res = {A[31], 8'hFF, 23'h0};
    end else begin
      spec_res = {~B[31], 8'hFF, 23'h0};
    end
`else
    hid_big    = 1'b1;
    hid_small  = 1'b1;
    spec_hit   = 1'b0;
    spec_res   = 32'h0;
    spec_err   = 1'b0;
`endif
  end

  // Add/subtract, normalization step size and rounding increment
  always_comb begin
    if (sign_x == sign_y) begin
      sum = {1'b0, man_x} + {1'b0, man_y};
    end else begin
      sum = {1'b0, man_x} - {1'b0, man_y};
    end
    norm_amt = ((NORM_STEP == 2) && !man_x[25]) ? 10'd2 : 10'd1;
    case (rm)
      2'b00:   round_inc = !sign_x && (man_x[2] | man_x[1] | man_x[0]);
      2'b01:   round_inc = sign_x && (man_x[2] | man_x[1] | man_x[0]);
      2'b10:   round_inc = man_x[2] && (man_x[1] | man_x[0] | man_x[3]);
      default: round_inc = man_x[2];
    endcase
    rounded = {1'b0, man_x[26:3]} + {24'h0, round_inc};
    exp_r   = exp_x + {9'h0, rounded[24]};
    mant_r  = rounded[24] ? rounded[24:1] : rounded[23:0];
  end

  // Control FSM and datapath registers, all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      resultSub    <= 32'h0;
      overflowSub  <= 1'b0;
      underflowSub <= 1'b0;
      errorSub     <= 1'b0;
      sign_x       <= 1'b0;
      sign_y       <= 1'b0;
      exp_x        <= 10'h0;
      man_x        <= 27'h0;
      man_y        <= 27'h0;
      cnt          <= 8'h0;
      rm           <= 2'b00;
      special_q    <= 1'b0;
      spec_res_q   <= 32'h0;
      spec_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_x     <= big_sign;
            sign_y     <= small_sign;
            exp_x      <= {2'b00, big_mag[30:23]};
            man_x      <= {hid_big, big_mag[22:0] & {23{hid_big}}, 3'b000};
            man_y      <= {hid_small, small_mag[22:0] & {23{hid_small}}, 3'b000};
            cnt        <= shift_init;
            rm         <= round_mode;
            special_q  <= spec_hit;
            spec_res_q <= spec_res;
            spec_err_q <= spec_err;
            in_ready   <= 1'b0;
            state      <= ALIGN;
          end
        end
        ALIGN: begin
          if (special_q) begin
            state <= ROUND;
          end else begin
            if (cnt != 8'h0) begin
              man_y <= {1'b0, man_y[26:2], man_y[1] | man_y[0]};
            end
            if (cnt <= 8'h1) begin
              state <= ADDSUB;
            end else begin
              cnt <= cnt - 8'h1;
            end
          end
        end
        ADDSUB: begin
          if (sum == 28'h0) begin
            resultSub    <= {(rm == 2'b01), 31'h0};
            overflowSub  <= 1'b0;
            underflowSub <= 1'b0;
            errorSub     <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (sum[27]) begin
            man_x <= {sum[27:2], sum[1] | sum[0]};
            exp_x <= exp_x + 10'h1;
            state <= NORM;
          end else begin
            man_x <= sum[26:0];
            state <= NORM;
          end
        end
        NORM: begin
          if (man_x[26]) begin
            state <= ROUND;
          end else if (exp_x <= norm_amt) begin
            resultSub    <= {sign_x, 31'h0};
            overflowSub  <= 1'b0;
            underflowSub <= 1'b1;
            errorSub     <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            man_x <= man_x << norm_amt;
            exp_x <= exp_x - norm_amt;
          end
        end
        ROUND: begin
          if (special_q) begin
            resultSub    <= spec_res_q;
            overflowSub  <= 1'b0;
            underflowSub <= 1'b0;
            errorSub     <= spec_err_q;
          end else if (exp_r >= 10'd255) begin
            resultSub    <= {sign_x, 8'hFF, 23'h0};
            overflowSub  <= 1'b1;
            underflowSub <= 1'b0;
            errorSub     <= 1'b1;
          end else begin
            resultSub    <= {sign_x, exp_r[7:0], mant_r[22:0]};
            overflowSub  <= 1'b0;
            underflowSub <= 1'b0;
            errorSub     <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: directed self-checking bench for fp_sub_seq with hand-computed vectors.
// Define FPU_SUB_SPECIAL_EN to also exercise the special-value path.
module tb_fp_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] resultSub;
  logic        overflowSub;
  logic        underflowSub;
  logic        errorSub;

  int errors = 0;
  int checks = 0;
  int lat;
  int seen;

  fp_sub_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (A),
    .B            (B),
    .round_mode   (round_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .resultSub    (resultSub),
    .overflowSub  (overflowSub),
    .underflowSub (underflowSub),
    .errorSub     (errorSub)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports tag/observed/expected on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one operand pair while idle, then count cycles until out_valid (bounded)
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] rm, output int cycles);
    A          = a;
    B          = b;
    round_mode = rm;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cycles   = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("timeout", {31'h0, out_valid}, 32'h1);
  endtask

  // Complete the output handshake and confirm the block is ready again
  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'h0, out_valid}, 32'h0);
    checkOutput({tag, "_ready_back"}, {31'h0, in_ready}, 32'h1);
  endtask

  // Full operation: run, compare result and flags, release
  task automatic runCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, input logic [31:0] expRes,
                         input logic expOv, input logic expUf, input logic expErr);
    int cyc;
    applyStimulus(a, b, rm, cyc);
    lat = cyc;
    checkOutput({tag, "_res"}, resultSub, expRes);
    checkOutput({tag, "_flags"}, {29'h0, overflowSub, underflowSub, errorSub},
                {29'h0, expOv, expUf, expErr});
    releaseResult(tag);
  endtask

  // Directed sequence
  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    A          = 32'h0;
    B          = 32'h0;
    round_mode = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_result", resultSub, 32'h0);
    checkOutput("rst_flags", {29'h0, overflowSub, underflowSub, errorSub}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3.0 - 1.0 = 2.0, d=1 and no normalization shift: latency 3+1+0
    runCase("three_minus_one", 32'h40400000, 32'h3F800000, 2'b10, 32'h40000000, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_d1", lat, 32'd4);

    // Exact cancellation: zero sign depends on round mode
    runCase("cancel_rne", 32'h3F800000, 32'h3F800000, 2'b10, 32'h00000000, 1'b0, 1'b0, 1'b0);
    runCase("cancel_rmi", 32'h3F800000, 32'h3F800000, 2'b01, 32'h80000000, 1'b0, 1'b0, 1'b0);

    // 1.0 - 2^-30: alignment saturates, everything lands in sticky
    runCase("tiny_rne", 32'h3F800000, 32'h30800000, 2'b10, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_sat", lat, 32'd30);
    runCase("tiny_rmi", 32'h3F800000, 32'h30800000, 2'b01, 32'h3F7FFFFF, 1'b0, 1'b0, 1'b0);
    runCase("tiny_rpi", 32'h3F800000, 32'h30800000, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b0);

    // 1.0 - (-2^-24): exact halfway case, even stays, ties-away and +inf round up
    runCase("half_rne", 32'h3F800000, 32'hB3800000, 2'b10, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    runCase("half_rta", 32'h3F800000, 32'hB3800000, 2'b11, 32'h3F800001, 1'b0, 1'b0, 1'b0);
    runCase("half_rpi", 32'h3F800000, 32'hB3800000, 2'b00, 32'h3F800001, 1'b0, 1'b0, 1'b0);

    // Effective addition and a negative difference
    runCase("one_minus_neg", 32'h3F800000, 32'hBF800000, 2'b10, 32'h40000000, 1'b0, 1'b0, 1'b0);
    runCase("one_minus_three", 32'h3F800000, 32'h40400000, 2'b10, 32'hC0000000, 1'b0, 1'b0, 1'b0);

    // Overflow: max - (-max)
    runCase("overflow", 32'h7F7FFFFF, 32'hFF7FFFFF, 2'b10, 32'h7F800000, 1'b1, 1'b0, 1'b1);

    // Back-pressure: result held with out_ready low, extra in_valid ignored
    applyStimulus(32'h40400000, 32'h3F800000, 2'b10, lat);
    A        = 32'h3F800000;
    B        = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_res", resultSub, 32'h40000000);
      checkOutput("hold_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    releaseResult("hold");

    // Reset during ALIGN aborts with no output
    A          = 32'h3F800000;
    B          = 32'h30800000;
    round_mode = 2'b10;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("abort_ready", {31'h0, in_ready}, 32'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("abort_no_output", seen, 32'd0);

    // Block still usable after the abort
    runCase("after_abort", 32'h40400000, 32'h3F800000, 2'b10, 32'h40000000, 1'b0, 1'b0, 1'b0);

`ifdef FPU_SUB_SPECIAL_EN
    // Inf - Inf is invalid and takes the short path
    runCase("inf_minus_inf", 32'h7F800000, 32'h7F800000, 2'b10, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
    checkOutput("lat_special", lat, 32'd2);
    runCase("inf_minus_one", 32'h7F800000, 32'h3F800000, 2'b10, 32'h7F800000, 1'b0, 1'b0, 1'b0);
    runCase("one_minus_inf", 32'h3F800000, 32'h7F800000, 2'b10, 32'hFF800000, 1'b0, 1'b0, 1'b0);
    runCase("zero_minus_one", 32'h00000000, 32'h3F800000, 2'b10, 32'hBF800000, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
